// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 pooling blocks.
// Pixel, pair-sum and quad-sum widths plus the /4 helper.
package pool_pkg;

  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] pixel_t;
  typedef logic [DATA_W:0]   pair_sum_t;
  typedef logic [DATA_W+1:0] quad_sum_t;

  // Floor of a 4-pixel sum divided by 4; fits a pixel.
  function automatic pixel_t avg4(input quad_sum_t s);
    return s[DATA_W+1:2];
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Holds the pair sums of the previous even row, one per output column.
// Ports: we_i/idx_i/wdata_i write port, rdata_o combinational read at idx_i.
module pool_line_buffer
  import pool_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int IW    = 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [IW-1:0] idx_i,
  input  pair_sum_t     wdata_i,
  output pair_sum_t     rdata_o
);

  pair_sum_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/avg_pool_stream.sv
// Streaming 2x2 stride-2 average pool over a WIDTH_IN square map.
// Ports: clk/reset_n, clear, in_* (valid/ready), out_* (valid/ready, last).
module avg_pool_stream
  import pool_pkg::*;
#(
  parameter int WIDTH_IN = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int WIDTH_OUT = WIDTH_IN / 2;
  localparam int CW = (WIDTH_IN > 2) ? $clog2(WIDTH_IN) : 1;
  localparam int IW = (WIDTH_OUT > 1) ? $clog2(WIDTH_OUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH_IN - 1);

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  pixel_t        pair_q, pair_d;
  pixel_t        dat_q, dat_d;
  logic          vld_q, vld_d;
  logic          lst_q, lst_d;

  logic          emit;
  logic          accept;
  logic          lb_we;
  logic [IW-1:0] lb_idx;
  pair_sum_t     lb_wd;
  pair_sum_t     lb_rd;
  quad_sum_t     quad;

  assign emit   = col_q[0] & row_q[0];
  assign in_ready = !clear && (!emit || !vld_q || out_ready);
  assign accept = in_valid && in_ready;

  assign lb_idx = IW'(col_q >> 1);
  assign lb_we  = accept && col_q[0] && !row_q[0];
  assign lb_wd  = pair_sum_t'(pair_q) + pair_sum_t'(in_data);
  assign quad   = quad_sum_t'(lb_rd)
                + quad_sum_t'(pair_q)
                + quad_sum_t'(in_data);

  pool_line_buffer #(
    .DEPTH (WIDTH_OUT),
    .IW    (IW)
  ) u_lb (
    .clk     (clk),
    .we_i    (lb_we),
    .idx_i   (lb_idx),
    .wdata_i (lb_wd),
    .rdata_o (lb_rd)
  );

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    pair_d = pair_q;
    dat_d  = dat_q;
    vld_d  = vld_q;
    lst_d  = lst_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
      vld_d = 1'b0;
      lst_d = 1'b0;
    end else begin
      // Drain first so a same-cycle emit overrides it.
      if (vld_q && out_ready) begin
        vld_d = 1'b0;
        lst_d = 1'b0;
      end
      if (accept) begin
        if (!col_q[0]) pair_d = in_data;
        if (emit) begin
          dat_d = avg4(quad);
          vld_d = 1'b1;
          lst_d = (row_q == LAST) && (col_q == LAST);
        end
        if (col_q == LAST) begin
          col_d = '0;
          row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q  <= '0;
      row_q  <= '0;
      pair_q <= '0;
      dat_q  <= '0;
      vld_q  <= 1'b0;
      lst_q  <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      pair_q <= pair_d;
      dat_q  <= dat_d;
      vld_q  <= vld_d;
      lst_q  <= lst_d;
    end
  end

  assign out_data  = dat_q;
  assign out_valid = vld_q;
  assign out_last  = lst_q;

endmodule
